// File: rtl/mux_frag_pkg.sv
// Shared types and sizing helpers for the mux_frag_cfg reconfigurable C-type fragment.
package mux_frag_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    function automatic int leaves(input int sel_w);
        return 2 ** sel_w;
    endfunction

    function automatic int cfg_len(input int sel_w, input int num_slices);
        return num_slices * leaves(sel_w);
    endfunction

endpackage

// File: rtl/mux_frag_slice.sv
// One fragment slice: per-leaf programmable inversion followed by a 2**SEL_W:1 mux tree.
module mux_frag_slice
    import mux_frag_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic [leaves(SEL_W)-1:0] din,
    input  logic [leaves(SEL_W)-1:0] mask,
    input  logic [SEL_W-1:0]         sel,
    output logic                     sz
);

    logic [leaves(SEL_W)-1:0] leaf;

    assign leaf = din ^ mask;
    assign sz   = leaf[sel];

endmodule

// File: rtl/mux_frag_cfg.sv
// Parametrised pp3 C-type mux fragment with a serially loaded, shadow/commit inversion mask.
// Optional build macro MUX_FRAG_OUT_REG_EN registers SZ/CZ (one cycle latency).
module mux_frag_cfg
    import mux_frag_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int NUM_SLICES = 2
) (
    input  logic                                QCK,
    input  logic                                QRT,
    input  logic [NUM_SLICES*(2**SEL_W)-1:0]    DIN,
    input  logic [NUM_SLICES*SEL_W-1:0]         SEL,
    input  logic [$clog2(NUM_SLICES)-1:0]       SSEL,
    output logic [NUM_SLICES-1:0]               SZ,
    output logic                                CZ,
    input  logic                                CFG_START,
    input  logic                                CFG_DI,
    input  logic                                CFG_VALID,
    output logic                                CFG_READY,
    output logic                                CFG_DONE
);

    localparam int LEAVES  = leaves(SEL_W);
    localparam int CFG_LEN = cfg_len(SEL_W, NUM_SLICES);
    localparam int CNT_W   = $clog2(CFG_LEN + 1);

    cfg_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CFG_LEN-1:0] shadow_q, shadow_d;
    logic [CFG_LEN-1:0] mask_q, mask_d;
    logic               ready_d, done_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CFG_START) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                ready_d = 1'b1;
                if (CFG_VALID) begin
                    // Bits enter at the MSB, so the first bit ends up at mask[0].
                    shadow_d = {CFG_DI, shadow_q[CFG_LEN-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CFG_LEN - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                mask_d  = shadow_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge QCK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (QRT) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
        end
    end

    assign CFG_READY = ready_d;
    assign CFG_DONE  = done_d;

    logic [NUM_SLICES-1:0] sz_d;
    logic                  cz_d;

    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        mux_frag_slice #(
            .SEL_W (SEL_W)
        ) u_slice (
            .din  (DIN[s*LEAVES +: LEAVES]),
            .mask (mask_q[s*LEAVES +: LEAVES]),
            .sel  (SEL[s*SEL_W +: SEL_W]),
            .sz   (sz_d[s])
        );
    end

    // Out-of-range slice selects (non power-of-two NUM_SLICES) read as 0.
    always_comb begin
        cz_d = 1'b0;
        if (int'(SSEL) < NUM_SLICES) begin
            cz_d = sz_d[SSEL];
        end
    end

`ifdef MUX_FRAG_OUT_REG_EN
    logic [NUM_SLICES-1:0] sz_q;
    logic                  cz_q;

    always_ff @(posedge QCK) begin
        if (QRT) begin
            sz_q <= '0;
            cz_q <= 1'b0;
        end else begin
            sz_q <= sz_d;
            cz_q <= cz_d;
        end
    end

    assign SZ = sz_q;
    assign CZ = cz_q;
`else
    assign SZ = sz_d;
    assign CZ = cz_d;
`endif

endmodule
